nibble_serial_adder_ctrl: RTL and testbench
===========================================

Name: nibble_serial_adder_ctrl

Overview:
- Sequencer that reuses one 4-bit ripple-carry adder slice to add WIDTH-bit operands, one nibble per clock, LSB nibble first.
- Carry is chained between nibbles through a register.
- Trades area for latency. Sits between a requester issuing start/operands and consumers sampling sum/cy_out on done.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4
NSLICE, WIDTH/4 (derived localparam, not overridable), number of nibble steps per operation

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request pulse; sampled on clk rising edge
a  input  WIDTH  operand A; sampled only on accepted start
b  input  WIDTH  operand B; sampled only on accepted start
cy_in  input  1  carry into nibble 0; sampled only on accepted start
busy  output  1  high while an operation is in progress (RUN state)
done  output  1  one-cycle pulse; sum/cy_out are valid from this cycle on
sum  output  WIDTH  result register
cy_out  output  1  carry out of the top nibble

Behaviour:
- One clock domain. Reset is asynchronous and active-low: rst_n low forces all state immediately, with no clock edge needed.
- Reset values: state=IDLE, busy=0, done=0, sum=0, cy_out=0, internal operand/carry/index registers=0.
- FSM states: IDLE, RUN, DONE.
  - IDLE: start=1 at an edge -> latch a, b into shadow registers, carry_reg<=cy_in, idx<=0, go to RUN.
  - RUN: each edge adds a_sh[4*idx+:4] + b_sh[4*idx+:4] + carry_reg through the 4-bit slice.
    - Writes the slice sum into acc[4*idx+:4] and the slice carry into carry_reg, then idx<=idx+1.
    - On the edge processing idx=NSLICE-1: sum<=full accumulated result (including this slice), cy_out<=slice carry, go to DONE.
  - DONE: lasts exactly one cycle, then goes to IDLE. start=1 in DONE is accepted exactly as in IDLE, so back-to-back operations are allowed.
- Outputs:
  - busy=1 exactly in RUN.
  - done=1 exactly in DONE.
  - sum/cy_out change only on the RUN->DONE edge and then hold until the next completion. No partial results are ever visible.
- Latency: start accepted at edge E -> busy high from E, done high in the cycle after edge E+NSLICE. WIDTH=16 gives done 4 cycles after the accept edge.
- start while busy=1 is ignored. It is not queued, and the operation in flight is unaffected.
- Changes on a/b/cy_in after acceptance have no effect, because the operands are shadow-latched.
- Arithmetic: result is exactly (a + b + cy_in) mod 2^WIDTH. cy_out is bit WIDTH of that sum. The carry must propagate across nibble boundaries, e.g. 0xFFFF+1.
- Reset mid-operation (rst_n low in RUN):
  - Abort immediately and return every register to its reset value, including sum=0.
  - No done pulse is issued for the aborted operation.
  - First accept is possible at the first edge after rst_n is released.
- The idx counter never exceeds NSLICE-1; it wraps to 0 only via a new accept.

Optional Feature:
- Macro: NIBBLE_SERIAL_ADDER_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), sampled with start.
  - sub=1 latches ~b instead of b and forces carry_reg<=1 (cy_in ignored), so result = (a - b) mod 2^WIDTH. cy_out=1 means no borrow (a>=b).
  - sub=0 behaves exactly as the base block.
- Not defined: the sub port does not exist; the block is an adder only.

Test Plan:
- Reset, then WIDTH=16, start with a=0x0000, b=0x0000, cy_in=0 -> busy high for 4 cycles, then done pulse; sum=0x0000, cy_out=0.
- a=0xFFFF, b=0x0001, cy_in=0 -> sum=0x0000, cy_out=1 (carry chained through all 4 nibbles). Separately, a=0x1234, b=0x4321, cy_in=1 -> sum=0x5556, cy_out=0.
- Accept a=0x00FF, b=0x0001; pulse start with a=0xAAAA, b=0x5555 while busy -> done once after 4 cycles, sum=0x0100. No second done follows.
- Back-to-back: start held high in DONE with a=0x8000, b=0x8000, cy_in=1 -> second done exactly 5 cycles after the first; sum=0x0001, cy_out=1. The first result stays held until then.
- Accept a=0x1111, b=0x2222; assert rst_n=0 after 2 RUN cycles -> busy/done/sum/cy_out are 0 immediately with no done pulse. After release, a=0x0003+b=0x0004 gives sum=0x0007.
- NIBBLE_SERIAL_ADDER_SUB_EN: sub=1, a=0x0005, b=0x0007 -> sum=0xFFFE, cy_out=0. Then sub=1, a=0x0007, b=0x0005 -> sum=0x0002, cy_out=1.

Source files
------------

// File: rtl/nibble_serial_adder_ctrl_if.sv
// nibble_serial_adder_ctrl_if
//   Request/result bundle for nibble_serial_adder_ctrl.
//   Requester side (master): drives start, a, b, cy_in (and sub when
//   NIBBLE_SERIAL_ADDER_SUB_EN is defined), samples busy, done, sum, cy_out.
//   Adder side (slave): the reverse.
//   Parameter WIDTH must match the connected adder's WIDTH.
interface nibble_serial_adder_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cy_in;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cy_out;

`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    modport master (output start, a, b, cy_in, sub, input busy, done, sum, cy_out);
    modport slave  (input start, a, b, cy_in, sub, output busy, done, sum, cy_out);
`else
    modport master (output start, a, b, cy_in, input busy, done, sum, cy_out);
    modport slave  (input start, a, b, cy_in, output busy, done, sum, cy_out);
`endif
endinterface

// File: rtl/nibble_serial_adder_ctrl.sv
// nibble_serial_adder_ctrl
//   Adds two WIDTH-bit operands through a single 4-bit ripple slice, one
//   nibble per clock, LSB nibble first, with the carry chained through a
//   register. Result and carry-out appear only on completion.
//   Ports:
//     clk   - rising-edge clock
//     rst_n - asynchronous active-low reset
//     bus   - nibble_serial_adder_ctrl_if.slave:
//             start/a/b/cy_in(/sub) in; busy/done/sum/cy_out out
//   Parameter WIDTH: operand width, multiple of 4, >= 4.
//   Optional macro NIBBLE_SERIAL_ADDER_SUB_EN: adds bus.sub; sub=1 computes
//   a - b (mod 2^WIDTH), cy_out=1 meaning no borrow.
module nibble_serial_adder_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    nibble_serial_adder_ctrl_if.slave     bus
);
    localparam int NSLICE = WIDTH / 4;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] sum_q;
    logic [IDXW-1:0]  idx_q;
    logic             carry_q;
    logic             cy_q;
    logic             busy_q;
    logic             done_q;

    logic [3:0]       a_nib;
    logic [3:0]       b_nib;
    logic [4:0]       slice_d;
    logic [WIDTH-1:0] acc_d;

    // The shared 4-bit slice and the accumulator with the current nibble
    // merged in; acc_d is what sum takes on the final step so that the
    // last slice is included.
    always_comb begin
        a_nib   = a_sh_q[4*idx_q +: 4];
        b_nib   = b_sh_q[4*idx_q +: 4];
        slice_d = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry_q};
        acc_d   = acc_q;
        acc_d[4*idx_q +: 4] = slice_d[3:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cy_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                // DONE accepts a new request exactly like IDLE.
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        a_sh_q <= bus.a;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
                        b_sh_q  <= bus.sub ? ~bus.b : bus.b;
                        carry_q <= bus.sub ? 1'b1 : bus.cy_in;
`else
                        b_sh_q  <= bus.b;
                        carry_q <= bus.cy_in;
`endif
                        acc_q   <= '0;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_RUN: begin
                    acc_q   <= acc_d;
                    carry_q <= slice_d[4];
                    if (idx_q == LAST_IDX) begin
                        sum_q   <= acc_d;
                        cy_q    <= slice_d[4];
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        idx_q <= idx_q + IDXW'(1);
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.sum    = sum_q;
    assign bus.cy_out = cy_q;
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// tb_nibble_serial_adder_ctrl
//   Self-checking bench: a cycle-level behavioural model (operation timer
//   plus plain arithmetic result) is compared against the DUT on every
//   falling edge, with directed literal checks and a random phase.
module tb_nibble_serial_adder_ctrl;
    localparam int W  = 16;
    localparam int NS = W / 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    nibble_serial_adder_ctrl_if #(.WIDTH(W)) bus ();

    nibble_serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit         m_busy, m_done, m_cy, m_nd;
    bit [W-1:0] m_sum;
    bit [W:0]   m_res;
    int         m_left;
    bit         m_sub;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0; m_done = 0; m_cy = 0; m_sum = '0; m_res = '0; m_left = 0;
        end else begin
            m_nd = 0;
            if (m_busy) begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 0;
                    m_nd   = 1;
                    {m_cy, m_sum} = m_res;
                end
            end else if (bus.start) begin
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
                m_sub = bus.sub;
`else
                m_sub = 0;
`endif
                if (m_sub)
                    m_res = {(bus.a >= bus.b), W'(bus.a - bus.b)};
                else
                    m_res = {1'b0, bus.a} + {1'b0, bus.b} + (W+1)'(bus.cy_in);
                m_busy = 1;
                m_left = NS;
            end
            m_done = m_nd;
        end
    end

    always @(negedge clk) begin
        chk("cycle{busy,done,cy,sum}", {13'd0, bus.busy, bus.done, bus.cy_out, bus.sum},
            {13'd0, m_busy, m_done, m_cy, m_sum});
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic [W-1:0] ai, input logic [W-1:0] bi,
                         input logic ci, input logic si);
        bus.a     = ai;
        bus.b     = bi;
        bus.cy_in = ci;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
        bus.sub   = si;
`else
        if (si) $display("note: sub requested without subtract support");
`endif
        bus.start = 1'b1;
    endtask

    // Called right after the negedge where start was raised; returns the
    // number of falling edges until done is seen (0 on timeout).
    task automatic wait_done(output int k, output int busyc);
        k = 0;
        busyc = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 1) bus.start = 1'b0;
            if (bus.busy) busyc++;
            if (bus.done) begin
                k = i;
                break;
            end
        end
        if (k == 0) chk("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic count_done(input int n, output int c);
        c = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (bus.done) c++;
        end
    endtask

    int k, bc, dc;

    initial begin
        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cy_in = 1'b0;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
        bus.sub = 1'b0;
`endif
        repeat (2) @(negedge clk);
        chk("reset_outputs", {13'd0, bus.busy, bus.done, bus.cy_out, bus.sum}, 32'd0);
        rst_n = 1'b1;

        // zero + zero
        @(negedge clk); drive(16'h0000, 16'h0000, 1'b0, 1'b0);
        wait_done(k, bc);
        chk("lat_zero", k, NS + 1);
        chk("busy_cycles", bc, NS);
        chk("sum_zero", {bus.cy_out, bus.sum}, {1'b0, 16'h0000});

        // carry ripple across every nibble
        @(negedge clk); drive(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        wait_done(k, bc);
        chk("sum_ffff_p1", {bus.cy_out, bus.sum}, {1'b1, 16'h0000});

        // carry-in
        @(negedge clk); drive(16'h1234, 16'h4321, 1'b1, 1'b0);
        wait_done(k, bc);
        chk("sum_cyin", {bus.cy_out, bus.sum}, {1'b0, 16'h5556});

        // back-to-back: start held during DONE
        drive(16'h8000, 16'h8000, 1'b1, 1'b0);
        wait_done(k, bc);
        chk("lat_b2b", k, NS + 1);
        chk("sum_b2b", {bus.cy_out, bus.sum}, {1'b1, 16'h0001});

        // start while busy is ignored
        @(negedge clk); drive(16'h00FF, 16'h0001, 1'b0, 1'b0);
        @(negedge clk); bus.start = 1'b0;
        @(negedge clk); drive(16'hAAAA, 16'h5555, 1'b0, 1'b0);
        wait_done(k, bc);
        chk("lat_ignored", k, NS - 1);
        chk("sum_ignored", {bus.cy_out, bus.sum}, {1'b0, 16'h0100});
        count_done(8, dc);
        chk("no_second_done", dc, 0);

        // reset mid-operation
        @(negedge clk); drive(16'h1111, 16'h2222, 1'b0, 1'b0);
        @(negedge clk); bus.start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk("abort_outputs", {13'd0, bus.busy, bus.done, bus.cy_out, bus.sum}, 32'd0);
        @(negedge clk); #2 rst_n = 1'b1;
        count_done(6, dc);
        chk("no_done_after_abort", dc, 0);
        drive(16'h0003, 16'h0004, 1'b0, 1'b0);
        wait_done(k, bc);
        chk("sum_after_reset", {bus.cy_out, bus.sum}, {1'b0, 16'h0007});

`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
        @(negedge clk); drive(16'h0005, 16'h0007, 1'b1, 1'b1);
        wait_done(k, bc);
        chk("sub_borrow", {bus.cy_out, bus.sum}, {1'b0, 16'hFFFE});
        @(negedge clk); drive(16'h0007, 16'h0005, 1'b0, 1'b1);
        wait_done(k, bc);
        chk("sub_noborrow", {bus.cy_out, bus.sum}, {1'b1, 16'h0002});
`endif

        // random phase: random start pulses (some while busy), operands
        // changing every cycle, and two asynchronous resets.
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            bus.start = ($urandom_range(0, 2) == 0);
            bus.a     = W'($urandom);
            bus.b     = W'($urandom);
            bus.cy_in = 1'($urandom);
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
            bus.sub   = 1'($urandom);
`endif
            if (c == 200 || c == 451) begin
                #2 rst_n = 1'b0;
                #4 rst_n = 1'b1;
            end
        end
        bus.start = 1'b0;
        repeat (NS + 2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
